// File: rtl/packet_switch_dbg_avmm_arb.sv
// packet_switch_dbg_avmm_arb
// Two-master arbiter for the packet-switch debug CSR AVMM bus. A host CSR
// master (m0) and a JTAG/debug master (m1) share one downstream command port.
// Grants are round-robin and only one transaction is in flight at a time.
// Read responses are routed back to the master that issued the read.
// Optional feature macro: PKT_SW_DBG_AVMM_TIMEOUT_EN. When it is defined, a
// read that gets no response within TIMEOUT_CYC cycles completes with
// TIMEOUT_DATA and sets err_sticky.
module packet_switch_dbg_avmm_arb #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH-1:0]   m0_writedata,
    input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
    output logic                    m0_waitrequest,
    output logic [DATA_WIDTH-1:0]   m0_readdata,
    output logic                    m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH-1:0]   m1_writedata,
    input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
    output logic                    m1_waitrequest,
    output logic [DATA_WIDTH-1:0]   m1_readdata,
    output logic                    m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0]   s_address,
    output logic [DATA_WIDTH-1:0]   s_writedata,
    output logic [DATA_WIDTH/8-1:0] s_byteenable,
    output logic                    s_read,
    output logic                    s_write,
    input  logic [DATA_WIDTH-1:0]   s_readdata,
    input  logic                    s_readdatavalid,
    output logic                    err_sticky
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d;        // master that wins a tie
    logic                    gnt_q, gnt_d;        // owner of the transaction in flight
    logic                    is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0]   s_address_q, s_address_d;
    logic [DATA_WIDTH-1:0]   s_writedata_q, s_writedata_d;
    logic [BE_WIDTH-1:0]     s_byteenable_q, s_byteenable_d;
    logic                    s_read_q, s_read_d;
    logic                    s_write_q, s_write_d;
    logic [DATA_WIDTH-1:0]   m0_readdata_q, m0_readdata_d;
    logic [DATA_WIDTH-1:0]   m1_readdata_q, m1_readdata_d;
    logic                    m0_rdv_q, m0_rdv_d;
    logic                    m1_rdv_q, m1_rdv_d;

    logic                    m0_req_s, m1_req_s;
    logic                    gnt_s, accept_s;
    logic                    sel_write_s;
    logic [ADDR_WIDTH-1:0]   sel_address_s;
    logic [DATA_WIDTH-1:0]   sel_writedata_s;
    logic [BE_WIDTH-1:0]     sel_byteenable_s;

`ifdef PKT_SW_DBG_AVMM_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    err_q, err_d;
    assign err_sticky = err_q;
`else
    logic                    unused_cfg_s;
    assign unused_cfg_s = ^{TIMEOUT_DATA, 32'(TIMEOUT_CYC)};
    assign err_sticky   = 1'b0;
`endif

    // Request decode, round-robin pick and selection of the winner's command fields
    always_comb begin
        m0_req_s = m0_read | m0_write;
        m1_req_s = m1_read | m1_write;
        if (m0_req_s && m1_req_s) begin
            gnt_s = ptr_q;
        end else if (m1_req_s) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
        // Reset masks the acceptance so waitrequest reads high while rst is held.
        accept_s = (state_q == IDLE) && (m0_req_s || m1_req_s) && !rst;
        if (gnt_s) begin
            sel_write_s      = m1_write;
            sel_address_s    = m1_address;
            sel_writedata_s  = m1_writedata;
            sel_byteenable_s = m1_byteenable;
        end else begin
            sel_write_s      = m0_write;
            sel_address_s    = m0_address;
            sel_writedata_s  = m0_writedata;
            sel_byteenable_s = m0_byteenable;
        end
    end

    assign m0_waitrequest   = ~(accept_s & ~gnt_s);
    assign m1_waitrequest   = ~(accept_s & gnt_s);
    assign m0_readdata      = m0_readdata_q;
    assign m1_readdata      = m1_readdata_q;
    assign m0_readdatavalid = m0_rdv_q;
    assign m1_readdatavalid = m1_rdv_q;
    assign s_address        = s_address_q;
    assign s_writedata      = s_writedata_q;
    assign s_byteenable     = s_byteenable_q;
    assign s_read           = s_read_q;
    assign s_write          = s_write_q;

    // Next-state logic: arbitration, one-cycle downstream strobe, response routing
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        gnt_d          = gnt_q;
        is_wr_d        = is_wr_q;
        s_address_d    = s_address_q;
        s_writedata_d  = s_writedata_q;
        s_byteenable_d = s_byteenable_q;
        s_read_d       = 1'b0;
        s_write_d      = 1'b0;
        m0_readdata_d  = m0_readdata_q;
        m1_readdata_d  = m1_readdata_q;
        m0_rdv_d       = 1'b0;
        m1_rdv_d       = 1'b0;
`ifdef PKT_SW_DBG_AVMM_TIMEOUT_EN
        cnt_d          = cnt_q;
        err_d          = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    gnt_d          = gnt_s;
                    ptr_d          = ~gnt_s;
                    // A request with both read and write set is a write.
                    is_wr_d        = sel_write_s;
                    s_address_d    = sel_address_s;
                    s_writedata_d  = sel_writedata_s;
                    s_byteenable_d = sel_byteenable_s;
                    s_write_d      = sel_write_s;
                    s_read_d       = ~sel_write_s;
                    state_d        = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
`ifdef PKT_SW_DBG_AVMM_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (is_wr_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (s_readdatavalid) begin
                    // Real data takes precedence even in the timeout expiry cycle.
                    if (gnt_q) begin
                        m1_readdata_d = s_readdata;
                        m1_rdv_d      = 1'b1;
                    end else begin
                        m0_readdata_d = s_readdata;
                        m0_rdv_d      = 1'b1;
                    end
                    state_d = RESP;
`ifdef PKT_SW_DBG_AVMM_TIMEOUT_EN
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYC - 1)) begin
                    if (gnt_q) begin
                        m1_readdata_d = TIMEOUT_DATA;
                        m1_rdv_d      = 1'b1;
                    end else begin
                        m0_readdata_d = TIMEOUT_DATA;
                        m0_rdv_d      = 1'b1;
                    end
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = WAIT_RD;
                end
`else
                end else begin
                    state_d = WAIT_RD;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= 1'b0;
            gnt_q          <= 1'b0;
            is_wr_q        <= 1'b0;
            s_address_q    <= '0;
            s_writedata_q  <= '0;
            s_byteenable_q <= '0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            m0_readdata_q  <= '0;
            m1_readdata_q  <= '0;
            m0_rdv_q       <= 1'b0;
            m1_rdv_q       <= 1'b0;
`ifdef PKT_SW_DBG_AVMM_TIMEOUT_EN
            cnt_q          <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            gnt_q          <= gnt_d;
            is_wr_q        <= is_wr_d;
            s_address_q    <= s_address_d;
            s_writedata_q  <= s_writedata_d;
            s_byteenable_q <= s_byteenable_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            m0_readdata_q  <= m0_readdata_d;
            m1_readdata_q  <= m1_readdata_d;
            m0_rdv_q       <= m0_rdv_d;
            m1_rdv_q       <= m1_rdv_d;
`ifdef PKT_SW_DBG_AVMM_TIMEOUT_EN
            cnt_q          <= cnt_d;
            err_q          <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_packet_switch_dbg_avmm_arb.sv
// Testbench for packet_switch_dbg_avmm_arb. A transaction-level model tracks
// whether the bus is free, which master a tie goes to (the one not granted
// most recently), the command expected on the downstream port and the read
// response owed to each master.
module tb_packet_switch_dbg_avmm_arb;

    localparam int          TO_CYC  = 12;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
`ifdef PKT_SW_DBG_AVMM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m0_address = 16'h0, m1_address = 16'h0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = 32'h0, m1_writedata = 32'h0;
    logic [3:0]  m0_byteenable = 4'h0, m1_byteenable = 4'h0;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [15:0] s_address;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_read, s_write, err_sticky;
    logic [31:0] s_readdata = 32'h0;
    logic        s_readdatavalid = 1'b0;

    packet_switch_dbg_avmm_arb #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    wire [1:0] wait_v = {m1_waitrequest, m0_waitrequest};
    wire [1:0] rdv_v  = {m1_readdatavalid, m0_readdatavalid};

    int n_cmp = 0;
    int n_bad = 0;

    // Master request state
    bit          has_req [2];
    bit          req_rd  [2];
    bit          req_wr  [2];
    logic [15:0] req_addr[2];
    logic [31:0] req_wd  [2];
    logic [3:0]  req_be  [2];

    // Reference model state
    bit          busy, release_nx, pend, pend_wr, rd_wait, resp_due, exp_err;
    int          pend_m, own_m, resp_m, rd_cnt, last_gnt, cyc;
    logic [15:0] pend_addr;
    logic [31:0] pend_wd, resp_data;
    logic [3:0]  pend_be;
    logic [31:0] last_rd[2];
    int          acc_cyc[2], acc_cnt[2], rdv_cnt[2];
    int          gnt_log[$], wr_cyc_log[$];
    logic [15:0] wr_addr_log[$];

    // Stimulus configuration
    int          req_pct = 0, stray_pct = 0, dly_min = 1, dly_max = 1;
    bit          no_resp = 1'b0, rd_only = 1'b0, use_fix = 1'b0, force_stray = 1'b0;
    logic [31:0] fix_data = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_ports();
        m0_read = has_req[0] & req_rd[0];  m0_write = has_req[0] & req_wr[0];
        m1_read = has_req[1] & req_rd[1];  m1_write = has_req[1] & req_wr[1];
        m0_address = req_addr[0]; m0_writedata = req_wd[0]; m0_byteenable = req_be[0];
        m1_address = req_addr[1]; m1_writedata = req_wd[1]; m1_byteenable = req_be[1];
    endtask

    task automatic set_req(input int m, input bit rd, input bit wr, input logic [15:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        has_req[m] = 1'b1; req_rd[m] = rd; req_wr[m] = wr;
        req_addr[m] = a; req_wd[m] = wd; req_be[m] = be;
    endtask

    task automatic new_req(input int m);
        int kind;
        kind = rd_only ? 0 : int'($urandom_range(2, 0));
        set_req(m, kind != 1, kind != 0, 16'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic do_reset();
        has_req[0] = 1'b0; has_req[1] = 1'b0;
        drive_ports();
        m1_read = 1'b1;              // a pending request must not be accepted under reset
        s_readdatavalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_wait0", m0_waitrequest, 1'b1);   chk("rst_wait1", m1_waitrequest, 1'b1);
        chk("rst_rdv0", m0_readdatavalid, 1'b0);  chk("rst_rdv1", m1_readdatavalid, 1'b0);
        chk("rst_rdata0", m0_readdata, 32'h0);    chk("rst_rdata1", m1_readdata, 32'h0);
        chk("rst_s_read", s_read, 1'b0);          chk("rst_s_write", s_write, 1'b0);
        chk("rst_s_addr", s_address, 16'h0);      chk("rst_s_wd", s_writedata, 32'h0);
        chk("rst_s_be", s_byteenable, 4'h0);      chk("rst_err", err_sticky, 1'b0);
        rst = 1'b0;
        drive_ports();
        busy = 0; release_nx = 0; pend = 0; rd_wait = 0; resp_due = 0; exp_err = 0;
        last_gnt = 1; last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        acc_cnt = '{0, 0}; rdv_cnt = '{0, 0};
        gnt_log.delete(); wr_cyc_log.delete(); wr_addr_log.delete();
    endtask

    // One clock cycle: check outputs after the edge, drive new inputs, check grant
    task automatic tick();
        int g;
        @(posedge clk); #1;
        cyc++;
        if (release_nx) begin busy = 0; release_nx = 0; end
        if (pend) begin
            chk("s_write", s_write, pend_wr);  chk("s_read", s_read, !pend_wr);
            chk("s_address", s_address, pend_addr);
            chk("s_byteenable", s_byteenable, pend_be);
            if (pend_wr) begin
                chk("s_writedata", s_writedata, pend_wd);
                wr_addr_log.push_back(s_address); wr_cyc_log.push_back(cyc);
                release_nx = 1;
            end else begin
                rd_wait = 1; own_m = pend_m;
                rd_cnt = no_resp ? TO_CYC + 1 : int'($urandom_range(dly_max, dly_min)) + 1;
            end
            pend = 0;
        end else begin
            chk("s_read_quiet", s_read, 1'b0); chk("s_write_quiet", s_write, 1'b0);
        end
        if (rdv_v[0]) rdv_cnt[0]++;
        if (rdv_v[1]) rdv_cnt[1]++;
        if (resp_due) begin
            chk("rdv_owner", rdv_v[resp_m], 1'b1); chk("rdv_other", rdv_v[1-resp_m], 1'b0);
            last_rd[resp_m] = resp_data; resp_due = 0; release_nx = 1;
        end else begin
            chk("rdv0_quiet", m0_readdatavalid, 1'b0); chk("rdv1_quiet", m1_readdatavalid, 1'b0);
        end
        chk("m0_readdata", m0_readdata, last_rd[0]);
        chk("m1_readdata", m1_readdata, last_rd[1]);
        chk("err_sticky", err_sticky, exp_err);

        s_readdatavalid = 1'b0; s_readdata = $urandom;
        if (rd_wait && !(no_resp && !TO_EN)) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                rd_wait = 0; resp_due = 1; resp_m = own_m;
                if (no_resp) begin
                    resp_data = TO_DATA; exp_err = 1;
                end else begin
                    resp_data = use_fix ? fix_data : $urandom;
                    s_readdatavalid = 1'b1; s_readdata = resp_data;
                end
            end
        end else if (!rd_wait && (force_stray || int'($urandom_range(99, 0)) < stray_pct)) begin
            s_readdatavalid = 1'b1; force_stray = 1'b0;
        end
        for (int m = 0; m < 2; m++)
            if (!has_req[m] && int'($urandom_range(99, 0)) < req_pct) new_req(m);
        drive_ports();
        #1;
        if (!busy && (has_req[0] || has_req[1])) begin
            g = (has_req[0] && has_req[1]) ? 1 - last_gnt : (has_req[1] ? 1 : 0);
            chk("wait_granted", wait_v[g], 1'b0); chk("wait_other", wait_v[1-g], 1'b1);
            pend = 1; pend_m = g; pend_wr = req_wr[g]; pend_addr = req_addr[g];
            pend_wd = req_wd[g]; pend_be = req_be[g];
            last_gnt = g; has_req[g] = 0; busy = 1;
            acc_cyc[g] = cyc; acc_cnt[g]++; gnt_log.push_back(g);
        end else begin
            chk("wait0_high", m0_waitrequest, 1'b1); chk("wait1_high", m1_waitrequest, 1'b1);
        end
    endtask

    initial begin
        has_req = '{0, 0}; req_rd = '{0, 0}; req_wr = '{0, 0};
        req_addr = '{16'h0, 16'h0}; req_wd = '{32'h0, 32'h0}; req_be = '{4'h0, 4'h0};
        cyc = 0;
        do_reset();

        // Single read from m0, response 3 cycles after s_read
        dly_min = 3; dly_max = 3; use_fix = 1; fix_data = 32'h1234_5678;
        set_req(0, 1, 0, 16'h8218, 32'h0, 4'hF);
        repeat (9) tick();
        chk("t1_m0_data", m0_readdata, 32'h1234_5678);
        chk("t1_m0_rdv_cnt", rdv_cnt[0], 1);
        chk("t1_m1_rdv_cnt", rdv_cnt[1], 0);
        use_fix = 0;

        // Simultaneous writes after reset: m0 first, m1 two cycles later
        do_reset();
        set_req(0, 0, 1, 16'h8220, 32'hA5A5_0001, 4'hF);
        set_req(1, 0, 1, 16'h8240, 32'h5A5A_0002, 4'h3);
        repeat (6) tick();
        chk("t2_acc_gap", acc_cyc[1] - acc_cyc[0], 2);
        chk("t2_n_writes", wr_addr_log.size(), 2);
        if (wr_addr_log.size() == 2) begin
            chk("t2_wr0_addr", wr_addr_log[0], 16'h8220);
            chk("t2_wr1_addr", wr_addr_log[1], 16'h8240);
            chk("t2_wr0_cyc", wr_cyc_log[0] - acc_cyc[0], 1);
            chk("t2_wr1_cyc", wr_cyc_log[1] - acc_cyc[1], 1);
        end

        // Continuous contention with reads: grants must alternate 0,1,0,1
        do_reset();
        rd_only = 1; req_pct = 100; dly_min = 1; dly_max = 1;
        for (int i = 0; i < 100 && gnt_log.size() < 8; i++) tick();
        req_pct = 0;
        repeat (12) tick();
        chk("t3_n_grants", gnt_log.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            chk("t3_grant_order", gnt_log[i], i % 2);
        chk("t3_rdv_m0", rdv_cnt[0], acc_cnt[0]);
        chk("t3_rdv_m1", rdv_cnt[1], acc_cnt[1]);
        rd_only = 0;

        // Read with no downstream response
        do_reset();
        no_resp = 1;
        set_req(1, 1, 0, 16'h8300, 32'h0, 4'hF);
        repeat (TO_CYC + 6) tick();
        chk("t4_m1_rdv_cnt", rdv_cnt[1], TO_EN ? 1 : 0);
        chk("t4_err", err_sticky, TO_EN ? 1'b1 : 1'b0);
        chk("t4_m1_data", m1_readdata, TO_EN ? TO_DATA : 32'h0);

        // Reset while waiting for read data, then a late response
        do_reset();
        set_req(1, 1, 0, 16'h8304, 32'h0, 4'hF);
        repeat (4) tick();
        do_reset();
        no_resp = 0; force_stray = 1;
        repeat (3) tick();
        chk("t5_no_rdv", rdv_cnt[0] + rdv_cnt[1], 0);
        dly_min = 2; dly_max = 2;
        set_req(1, 1, 0, 16'h8308, 32'h0, 4'hF);
        repeat (8) tick();
        chk("t5_m1_acc", acc_cnt[1], 1);
        chk("t5_m1_rdv", rdv_cnt[1], 1);

        // Stray responses while idle, then normal traffic
        do_reset();
        force_stray = 1; tick();
        force_stray = 1; tick();
        set_req(0, 1, 1, 16'h8400, 32'hCAFE_F00D, 4'hC);
        repeat (4) tick();
        set_req(0, 1, 0, 16'h8404, 32'h0, 4'hF);
        repeat (8) tick();
        chk("t6_m0_acc", acc_cnt[0], 2);
        chk("t6_m0_rdv", rdv_cnt[0], 1);

        // Random traffic with stray strobes and variable read latency
        do_reset();
        req_pct = 40; stray_pct = 10; dly_min = 1; dly_max = 4;
        repeat (800) tick();
        req_pct = 0; stray_pct = 0;
        repeat (20) tick();
        chk("rand_progress", (acc_cnt[0] > 20) && (acc_cnt[1] > 20), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
